// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller:
// FSM states, opcodes, ALU function codes and mux select codes.
package mcpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_LS = 4'd2,
    S_MEM    = 4'd3,
    S_WB_LD  = 4'd4,
    S_EXE_BR = 4'd5,
    S_EXE_AL = 4'd6,
    S_WB_AL  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LS,
    CL_BR,
    CL_JMP,
    CL_HALT,
    CL_ILL
  } iclass_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_ANDI = 6'b010011;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // andi uses its own code: the ALU zero-extends only on 111
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_ANDI = 3'b111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

endpackage

// File: rtl/mcpu_opcode_decode.sv
// Combinational opcode/flag decoder producing datapath selects
// and an instruction class for the control FSM.
module mcpu_opcode_decode
  import mcpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                sign,
  output iclass_t             iclass,
  output logic                is_lw,
  output logic                is_jal,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                ExtSel,
  output logic                DBDATASrc,
  output logic                WrRegDSrc,
  output logic [2:0]          ALUOp,
  output logic [1:0]          PCSrc,
  output logic [1:0]          RegDst
);

  typedef logic [OPCODE_W-1:0] op_t;

  always_comb begin
    iclass    = CL_ILL;
    is_lw     = 1'b0;
    is_jal    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    DBDATASrc = 1'b0;
    WrRegDSrc = 1'b1;
    ALUOp     = ALU_ADD;
    PCSrc     = PC_SEQ;
    RegDst    = RD_RD;
    unique case (1'b1)
      opcode == op_t'(OP_ADD): iclass = CL_ALU;
      opcode == op_t'(OP_SUB): begin
        iclass = CL_ALU;
        ALUOp  = ALU_SUB;
      end
      opcode == op_t'(OP_ADDI): begin
        iclass  = CL_ALU;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        RegDst  = RD_RT;
      end
      opcode == op_t'(OP_OR): begin
        iclass = CL_ALU;
        ALUOp  = ALU_OR;
      end
      opcode == op_t'(OP_AND): begin
        iclass = CL_ALU;
        ALUOp  = ALU_AND;
      end
      opcode == op_t'(OP_ORI): begin
        iclass  = CL_ALU;
        ALUOp   = ALU_OR;
        ALUSrcB = 1'b1;
        RegDst  = RD_RT;
      end
      opcode == op_t'(OP_ANDI): begin
        iclass  = CL_ALU;
        ALUOp   = ALU_ANDI;
        ALUSrcB = 1'b1;
        RegDst  = RD_RT;
      end
      opcode == op_t'(OP_SLL): begin
        iclass  = CL_ALU;
        ALUOp   = ALU_SLL;
        ALUSrcA = 1'b1;
      end
      opcode == op_t'(OP_SLT): begin
        iclass = CL_ALU;
        ALUOp  = ALU_SLT;
      end
      opcode == op_t'(OP_SLTI): begin
        iclass  = CL_ALU;
        ALUOp   = ALU_SLT;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        RegDst  = RD_RT;
      end
      opcode == op_t'(OP_SW): begin
        iclass  = CL_LS;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        RegDst  = RD_RT;
      end
      opcode == op_t'(OP_LW): begin
        iclass    = CL_LS;
        is_lw     = 1'b1;
        ALUSrcB   = 1'b1;
        ExtSel    = 1'b1;
        DBDATASrc = 1'b1;
        RegDst    = RD_RT;
      end
      opcode == op_t'(OP_BEQ): begin
        iclass = CL_BR;
        ALUOp  = ALU_SUB;
        ExtSel = 1'b1;
        PCSrc  = zero ? PC_BR : PC_SEQ;
      end
      opcode == op_t'(OP_BNE): begin
        iclass = CL_BR;
        ALUOp  = ALU_SUB;
        ExtSel = 1'b1;
        PCSrc  = zero ? PC_SEQ : PC_BR;
      end
      opcode == op_t'(OP_BLTZ): begin
        iclass = CL_BR;
        ALUOp  = ALU_SUB;
        ExtSel = 1'b1;
        PCSrc  = sign ? PC_BR : PC_SEQ;
      end
      opcode == op_t'(OP_J): begin
        iclass = CL_JMP;
        PCSrc  = PC_JMP;
      end
      opcode == op_t'(OP_JR): begin
        iclass = CL_JMP;
        PCSrc  = PC_JR;
      end
      opcode == op_t'(OP_JAL): begin
        iclass    = CL_JMP;
        is_jal    = 1'b1;
        PCSrc     = PC_JMP;
        WrRegDSrc = 1'b0;
        RegDst    = RD_RA;
      end
      opcode == op_t'(OP_HALT): iclass = CL_HALT;
      default: iclass = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multicycle control FSM with variable-latency memory wait and timeout.
// ILLEGAL_OP_TRAP_EN: undecoded opcodes halt and raise sticky illegal_op.
module mcpu_ctrl_fsm
  import mcpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                sign,
  input  logic                mem_ready,
  output logic [3:0]          State,
  output logic                PCWre,
  output logic                IRWre,
  output logic                RegWre,
  output logic                mRD,
  output logic                mWR,
  output logic                InsMemRW,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                ExtSel,
  output logic                DBDATASrc,
  output logic                WrRegDSrc,
  output logic [2:0]          ALUOp,
  output logic [1:0]          PCSrc,
  output logic [1:0]          RegDst,
  output logic                retire,
  output logic                halted,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic                illegal_op,
`endif
  output logic                mem_err
);

  state_t           state, nxt;
  logic [TMO_W-1:0] cnt, cnt_d;
  logic             err_set;
  iclass_t          iclass;
  logic             is_lw, is_jal;

  mcpu_opcode_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode    (opcode),
    .zero      (zero),
    .sign      (sign),
    .iclass    (iclass),
    .is_lw     (is_lw),
    .is_jal    (is_jal),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .DBDATASrc (DBDATASrc),
    .WrRegDSrc (WrRegDSrc),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .RegDst    (RegDst)
  );

`ifdef ILLEGAL_OP_TRAP_EN
  logic ill_set;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= S_IF;
      cnt     <= '0;
      mem_err <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      cnt     <= cnt_d;
      mem_err <= mem_err | err_set;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op <= illegal_op | ill_set;
`endif
    end
  end

  always_comb begin
    nxt      = state;
    cnt_d    = '0;
    err_set  = 1'b0;
    PCWre    = 1'b0;
    IRWre    = 1'b0;
    RegWre   = 1'b0;
    mRD      = 1'b0;
    mWR      = 1'b0;
    InsMemRW = 1'b1;
    halted   = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    ill_set  = 1'b0;
`endif
    unique case (state)
      S_IF: begin
        IRWre = 1'b1;
        nxt   = S_ID;
      end
      S_ID: begin
        unique case (iclass)
          CL_HALT: nxt = S_HALT;
          CL_JMP: begin
            PCWre  = 1'b1;
            RegWre = is_jal;
            nxt    = S_IF;
          end
          CL_BR: nxt = S_EXE_BR;
          CL_LS: nxt = S_EXE_LS;
`ifdef ILLEGAL_OP_TRAP_EN
          CL_ILL: begin
            nxt     = S_HALT;
            ill_set = 1'b1;
          end
`endif
          default: nxt = S_EXE_AL;
        endcase
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        nxt   = S_IF;
      end
      S_EXE_LS: nxt = S_MEM;
      S_MEM: begin
        mRD = is_lw;
        mWR = ~is_lw;
        // a ready on the timeout cycle still completes normally
        if (mem_ready) begin
          if (is_lw) begin
            nxt = S_WB_LD;
          end else begin
            PCWre = 1'b1;
            nxt   = S_IF;
          end
        end else if (cnt == TMO_W'(MEM_TIMEOUT)) begin
          nxt     = S_HALT;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt + TMO_W'(1);
        end
      end
      S_WB_LD: begin
        RegWre = 1'b1;
        PCWre  = 1'b1;
        nxt    = S_IF;
      end
      S_EXE_AL: nxt = S_WB_AL;
      S_WB_AL: begin
        RegWre = 1'b1;
        PCWre  = 1'b1;
        nxt    = S_IF;
      end
      S_HALT: begin
        InsMemRW = 1'b0;
        halted   = 1'b1;
      end
      default: nxt = S_IF;
    endcase
  end

  assign State  = state;
  assign retire = PCWre;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Directed self-checking bench for mcpu_ctrl_fsm.
// Inputs change 2ns after the rising edge, outputs are checked 1ns later.
module tb_mcpu_ctrl_fsm;

  logic       CLK, Reset;
  logic [5:0] opcode;
  logic       zero, sign, mem_ready;
  logic [3:0] State;
  logic       PCWre, IRWre, RegWre, mRD, mWR, InsMemRW;
  logic       ALUSrcA, ALUSrcB, ExtSel, DBDATASrc, WrRegDSrc;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc, RegDst;
  logic       retire, halted, mem_err;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mcpu_ctrl_fsm dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .opcode    (opcode),
    .zero      (zero),
    .sign      (sign),
    .mem_ready (mem_ready),
    .State     (State),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .mRD       (mRD),
    .mWR       (mWR),
    .InsMemRW  (InsMemRW),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .DBDATASrc (DBDATASrc),
    .WrRegDSrc (WrRegDSrc),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .RegDst    (RegDst),
    .retire    (retire),
    .halted    (halted),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .mem_err   (mem_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; opcode = 6'b000000;
    zero = 1'b0; sign = 1'b0; mem_ready = 1'b0;

    // reset state
    tick(); tick(); #1;
    chk("rst_state", 8'(State), 8'd0);
    chk("rst_irwre", 8'(IRWre), 8'd1);
    chk("rst_imrw", 8'(InsMemRW), 8'd1);
    chk("rst_pcwre", 8'(PCWre), 8'd0);
    chk("rst_regwre", 8'(RegWre), 8'd0);
    chk("rst_memerr", 8'(mem_err), 8'd0);
    chk("rst_halted", 8'(halted), 8'd0);

    // add: 0,1,6,7,0
    Reset = 1'b0; opcode = 6'b000000;
    tick(); #1;
    chk("add_id", 8'(State), 8'd1);
    chk("add_id_pcwre", 8'(PCWre), 8'd0);
    tick(); #1;
    chk("add_exe", 8'(State), 8'd6);
    chk("add_exe_regwre", 8'(RegWre), 8'd0);
    chk("add_aluop", 8'(ALUOp), 8'd0);
    tick(); #1;
    chk("add_wb", 8'(State), 8'd7);
    chk("add_wb_regwre", 8'(RegWre), 8'd1);
    chk("add_wb_retire", 8'(retire), 8'd1);
    chk("add_regdst", 8'(RegDst), 8'd2);
    tick(); #1;
    chk("add_if", 8'(State), 8'd0);
    chk("add_if_retire", 8'(retire), 8'd0);

    // lw with 3 wait cycles
    opcode = 6'b110001;
    tick(); tick(); #1;
    chk("lw_exe", 8'(State), 8'd2);
    chk("lw_srcb", 8'(ALUSrcB), 8'd1);
    chk("lw_ext", 8'(ExtSel), 8'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) mem_ready = 1'b1;
      #1;
      chk("lw_mem_state", 8'(State), 8'd3);
      chk("lw_mem_mrd", 8'(mRD), 8'd1);
      chk("lw_mem_mwr", 8'(mWR), 8'd0);
      chk("lw_mem_pcwre", 8'(PCWre), 8'd0);
    end
    tick(); mem_ready = 1'b0; #1;
    chk("lw_wb", 8'(State), 8'd4);
    chk("lw_wb_regwre", 8'(RegWre), 8'd1);
    chk("lw_wb_dbsrc", 8'(DBDATASrc), 8'd1);
    chk("lw_wb_regdst", 8'(RegDst), 8'd1);
    chk("lw_wb_retire", 8'(retire), 8'd1);
    tick(); #1;
    chk("lw_if", 8'(State), 8'd0);

    // beq taken, bne not taken
    opcode = 6'b110100; zero = 1'b1;
    tick(); tick(); #1;
    chk("beq_state", 8'(State), 8'd5);
    chk("beq_pcsrc", 8'(PCSrc), 8'd1);
    chk("beq_pcwre", 8'(PCWre), 8'd1);
    chk("beq_aluop", 8'(ALUOp), 8'd1);
    tick(); opcode = 6'b110101; #1;
    chk("beq_if", 8'(State), 8'd0);
    tick(); tick(); #1;
    chk("bne_state", 8'(State), 8'd5);
    chk("bne_pcsrc", 8'(PCSrc), 8'd0);
    chk("bne_pcwre", 8'(PCWre), 8'd1);
    tick(); zero = 1'b0; #1;
    chk("bne_if", 8'(State), 8'd0);

    // sw with mem_ready stuck low times out after 16 MEM cycles
    opcode = 6'b110000;
    tick(); tick(); tick(); #1;
    chk("swto_mem", 8'(State), 8'd3);
    chk("swto_mwr", 8'(mWR), 8'd1);
    for (int i = 2; i <= 16; i++) begin
      tick(); #1;
      chk("swto_wait", 8'(State), 8'd3);
    end
    chk("swto_err_pre", 8'(mem_err), 8'd0);
    tick(); #1;
    chk("swto_halt", 8'(State), 8'd8);
    chk("swto_memerr", 8'(mem_err), 8'd1);
    chk("swto_halted", 8'(halted), 8'd1);
    chk("swto_mwr_off", 8'(mWR), 8'd0);
    chk("swto_imrw", 8'(InsMemRW), 8'd0);
    mem_ready = 1'b1; opcode = 6'b000000;
    tick(); tick(); tick(); #1;
    chk("swto_sticky", 8'(State), 8'd8);
    chk("swto_err_sticky", 8'(mem_err), 8'd1);
    chk("swto_pcwre", 8'(PCWre), 8'd0);

    // reset held 2 cycles mid MEM wait
    Reset = 1'b1; mem_ready = 1'b0;
    tick();
    Reset = 1'b0; opcode = 6'b110000;
    tick(); tick(); tick(); tick(); #1;
    chk("mid_mem", 8'(State), 8'd3);
    Reset = 1'b1;
    tick(); tick(); #1;
    chk("mid_rst_state", 8'(State), 8'd0);
    chk("mid_rst_irwre", 8'(IRWre), 8'd1);
    chk("mid_rst_memerr", 8'(mem_err), 8'd0);
    Reset = 1'b0;
    tick(); #1;
    chk("mid_rst_id", 8'(State), 8'd1);

    // sw ready on the 16th MEM cycle completes (counter restarted)
    tick(); tick(); #1;
    chk("swb_mem", 8'(State), 8'd3);
    for (int i = 2; i <= 16; i++) begin
      tick();
      if (i == 16) mem_ready = 1'b1;
      #1;
      chk("swb_wait", 8'(State), 8'd3);
    end
    chk("swb_pcwre", 8'(PCWre), 8'd1);
    chk("swb_retire", 8'(retire), 8'd1);
    tick(); mem_ready = 1'b0; #1;
    chk("swb_if", 8'(State), 8'd0);
    chk("swb_memerr", 8'(mem_err), 8'd0);

    // jal
    opcode = 6'b111010;
    tick(); #1;
    chk("jal_state", 8'(State), 8'd1);
    chk("jal_regwre", 8'(RegWre), 8'd1);
    chk("jal_regdst", 8'(RegDst), 8'd0);
    chk("jal_wrsrc", 8'(WrRegDSrc), 8'd0);
    chk("jal_pcsrc", 8'(PCSrc), 8'd3);
    chk("jal_pcwre", 8'(PCWre), 8'd1);
    tick(); opcode = 6'b111111; #1;
    chk("jal_if", 8'(State), 8'd0);

    // halt
    tick(); tick(); #1;
    chk("halt_state", 8'(State), 8'd8);
    chk("halt_imrw", 8'(InsMemRW), 8'd0);
    chk("halt_halted", 8'(halted), 8'd1);
    chk("halt_memerr", 8'(mem_err), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
